// File: rtl/pacman_video_pkg.sv
// Shared Pacman video constants, FIFO entry type, fetch FSM states and the
// tile-to-frame-buffer address mapping.
package pacman_video_pkg;

    localparam int          TILE_COLS = 28;
    localparam int          TILE_ROWS = 36;
    localparam logic [15:0] FB_BASE   = 16'h4000;
    localparam logic [15:0] COLOR_OFS = 16'h0400;

    typedef struct packed {
        logic [7:0] code;
        logic [7:0] color;
        logic [4:0] col;
        logic [5:0] row;
    } tile_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } fetch_state_t;

    // Screen columns run right-to-left in video RAM; the top and bottom two
    // rows are stored row-major, the playfield column-major.
    function automatic logic [15:0] tile_addr(input logic [4:0] col, input logic [5:0] row);
        logic [15:0] c;
        logic [15:0] r;
        logic [15:0] ofs;
        c = 16'(TILE_COLS - 1) - {11'b0, col};
        r = {10'b0, row};
        if (r < 16'd2) begin
            ofs = 16'h03C2 + (r << 5) + c;
        end else if (r < 16'd34) begin
            ofs = 16'h0040 + (c << 5) + (r - 16'd2);
        end else begin
            ofs = 16'h0002 + ((r - 16'd34) << 5) + c;
        end
        return FB_BASE + ofs;
    endfunction

endpackage

// File: rtl/pacman_tile_fetch_if.sv
// Frame-buffer request and tile-stream bundle of pacman_tile_fetch.
// TILE_FETCH_OVERRUN_EN adds the overrun_cnt status field.
interface pacman_tile_fetch_if;

    logic        frame_start;
    logic [15:0] gpu_addr_out1;
    logic [15:0] gpu_addr_out2;
    logic [7:0]  fb_douta;
    logic [7:0]  fb_doutb;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_code;
    logic [7:0]  tile_color;
    logic [4:0]  tile_col;
    logic [5:0]  tile_row;
    logic        frame_busy;
    logic        frame_done;
`ifdef TILE_FETCH_OVERRUN_EN
    logic [7:0]  overrun_cnt;
`endif

    modport master (
        input  frame_start, fb_douta, fb_doutb, tile_ready,
        output gpu_addr_out1, gpu_addr_out2, tile_valid, tile_code, tile_color,
               tile_col, tile_row, frame_busy, frame_done
`ifdef TILE_FETCH_OVERRUN_EN
        , output overrun_cnt
`endif
    );

    modport slave (
        output frame_start, fb_douta, fb_doutb, tile_ready,
        input  gpu_addr_out1, gpu_addr_out2, tile_valid, tile_code, tile_color,
               tile_col, tile_row, frame_busy, frame_done
`ifdef TILE_FETCH_OVERRUN_EN
        , input overrun_cnt
`endif
    );

endinterface

// File: rtl/tile_fifo.sv
// Synchronous first-word-fall-through FIFO of tile entries with occupancy count.
module tile_fifo
    import pacman_video_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push,
    input  tile_entry_t                  din,
    input  logic                         pop,
    output tile_entry_t                  dout,
    output logic                         valid,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    tile_entry_t   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push;
    logic          do_pop;

    // A pop frees a slot in the same cycle, so push-on-full is accepted with it.
    always_comb begin
        do_pop   = pop && (count_q != '0);
        do_push  = push && ((count_q != CW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        count_d  = count_q + CW'(do_push) - CW'(do_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign valid = (count_q != '0);
    assign dout  = valid ? mem_q[rd_ptr_q] : '0;
    assign count = count_q;

endmodule

// File: rtl/pacman_tile_fetch.sv
// Scans the 28x36 tile map each frame, reads code/colour bytes from the frame
// buffer and queues them for the renderer. TILE_FETCH_OVERRUN_EN adds overrun_cnt.
module pacman_tile_fetch
    import pacman_video_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned RD_LAT     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    pacman_tile_fetch_if.master  bus
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t               state_q, state_d;
    logic [4:0]                 col_q, col_d;
    logic [5:0]                 row_q, row_d;
    logic                       issue_q, issue_d;
    logic [15:0]                addr1_q, addr1_d;
    logic [15:0]                addr2_q, addr2_d;
    logic [10:0]                tag_q, tag_d;
    logic [RD_LAT-1:0]          pvld_q, pvld_d;
    logic [RD_LAT-1:0][10:0]    ptag_q, ptag_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;

    logic [CW-1:0]              fifo_count;
    logic [CW-1:0]              inflight;
    logic [CW-1:0]              occ_next;
    logic                       head_valid;
    logic                       pop;
    tile_entry_t                cap_entry;
    tile_entry_t                head;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        issue_d = 1'b0;
        addr1_d = '0;
        addr2_d = '0;
        tag_d   = tag_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        pop = head_valid && bus.tile_ready;

        // Slots already promised: FIFO contents plus every read still in the
        // address/latency pipeline, less the entry leaving this cycle.
        inflight = CW'(issue_q);
        for (int unsigned i = 0; i < RD_LAT; i++) begin
            inflight = inflight + CW'(pvld_q[i]);
        end
        occ_next = fifo_count + inflight - CW'(pop);

        case (state_q)
            FETCH: begin
                if (occ_next < CW'(FIFO_DEPTH)) begin
                    issue_d = 1'b1;
                    addr1_d = tile_addr(col_q, row_q);
                    addr2_d = tile_addr(col_q, row_q) + COLOR_OFS;
                    tag_d   = {col_q, row_q};
                    if (col_q == 5'(TILE_COLS - 1)) begin
                        col_d = '0;
                        if (row_q == 6'(TILE_ROWS - 1)) begin
                            row_d   = '0;
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 6'd1;
                        end
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
            end
            DRAIN: begin
                // busy stays up through the done pulse so a coincident
                // frame_start is still treated as arriving mid-frame.
                if (done_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else if (occ_next == '0) begin
                    done_d = 1'b1;
                end
            end
            default: begin
                if (bus.frame_start) begin
                    state_d = FETCH;
                    col_d   = '0;
                    row_d   = '0;
                    busy_d  = 1'b1;
                end
            end
        endcase

        pvld_d[0] = issue_q;
        ptag_d[0] = tag_q;
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            col_q   <= '0;
            row_q   <= '0;
            issue_q <= 1'b0;
            addr1_q <= '0;
            addr2_q <= '0;
            tag_q   <= '0;
            pvld_q  <= '0;
            ptag_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            issue_q <= issue_d;
            addr1_q <= addr1_d;
            addr2_q <= addr2_d;
            tag_q   <= tag_d;
            pvld_q  <= pvld_d;
            ptag_q  <= ptag_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign cap_entry = {bus.fb_douta, bus.fb_doutb, ptag_q[RD_LAT-1]};

    tile_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (pvld_q[RD_LAT-1]),
        .din   (cap_entry),
        .pop   (pop),
        .dout  (head),
        .valid (head_valid),
        .count (fifo_count)
    );

    assign bus.gpu_addr_out1 = addr1_q;
    assign bus.gpu_addr_out2 = addr2_q;
    assign bus.tile_valid    = head_valid;
    assign bus.tile_code     = head.code;
    assign bus.tile_color    = head.color;
    assign bus.tile_col      = head.col;
    assign bus.tile_row      = head.row;
    assign bus.frame_busy    = busy_q;
    assign bus.frame_done    = done_q;

`ifdef TILE_FETCH_OVERRUN_EN
    logic [7:0] ovr_q, ovr_d;

    always_comb begin
        ovr_d = ovr_q;
        if (bus.frame_start && busy_q && (ovr_q != 8'hFF)) begin
            ovr_d = ovr_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ovr_q <= '0;
        end else begin
            ovr_q <= ovr_d;
        end
    end

    assign bus.overrun_cnt = ovr_q;
`endif

endmodule

// File: tb/tb_pacman_tile_fetch.sv
// Scoreboard bench for pacman_tile_fetch: expected addresses and tile entries
// are queued at frame start and checked by a negedge monitor.
module tb_pacman_tile_fetch;

    localparam int NTILES = 1008;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pacman_tile_fetch_if bus ();

    pacman_tile_fetch #(
        .FIFO_DEPTH (8),
        .RD_LAT     (1)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Frame-buffer model, one cycle latency: code = offset[7:0], colour = ~offset[7:0].
    always @(posedge clk) begin
        bus.fb_douta <= 8'(bus.gpu_addr_out1 - 16'h4000);
        bus.fb_doutb <= ~8'(bus.gpu_addr_out2 - 16'h4400);
    end

    int n_chk = 0;
    int n_err = 0;
    int pops = 0;
    int issues = 0;
    int done_cnt = 0;
    int exp_done = 0;
    logic [15:0] addr_log [NTILES];
    logic [26:0] exp_q [$];
    logic [15:0] addr_q [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] exp_off(input int col, input int row);
        int c;
        c = 27 - col;
        if (row < 2)       return 16'(962 + row * 32 + c);
        else if (row < 34) return 16'(64 + c * 32 + (row - 2));
        else               return 16'(2 + (row - 34) * 32 + c);
    endfunction

    task automatic pulse_start();
        @(posedge clk); #1;
        bus.frame_start = 1'b1;
        @(posedge clk); #1;
        bus.frame_start = 1'b0;
    endtask

    task automatic start_frame();
        logic [15:0] o;
        for (int r = 0; r < 36; r++) begin
            for (int c = 0; c < 28; c++) begin
                o = exp_off(c, r);
                addr_q.push_back(16'h4000 + o);
                exp_q.push_back({o[7:0], ~o[7:0], 5'(c), 6'(r)});
            end
        end
        pops   = 0;
        issues = 0;
        pulse_start();
    endtask

    task automatic wait_done(input int limit, input bit rnd);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < limit && done_cnt == d0; i++) begin
            @(posedge clk); #1;
            if (rnd) bus.tile_ready = ($urandom_range(0, 9) < 3);
        end
        check("frame_done_seen", done_cnt, d0 + 1);
        exp_done++;
        bus.tile_ready = 1'b1;
    endtask

    always @(negedge clk) begin
        if (!reset) begin
            if (bus.gpu_addr_out1 != 16'h0) begin
                if (addr_q.size() == 0) begin
                    check("extra_issue", bus.gpu_addr_out1, 32'h0);
                end else begin
                    logic [15:0] e;
                    e = addr_q.pop_front();
                    check("issue_addr1", bus.gpu_addr_out1, e);
                    check("issue_addr2", bus.gpu_addr_out2, e + 16'h0400);
                end
                if (issues < NTILES) addr_log[issues] = bus.gpu_addr_out1;
                issues++;
            end else begin
                check("idle_addr2", bus.gpu_addr_out2, 32'h0);
            end
            if (pops > 0 && pops < NTILES) check("busy_high", bus.frame_busy, 1);
            if (bus.tile_valid && bus.tile_ready) begin
                if (exp_q.size() == 0) begin
                    check("extra_pop", 1, 0);
                end else begin
                    check("tile_entry",
                          {bus.tile_code, bus.tile_color, bus.tile_col, bus.tile_row},
                          exp_q.pop_front());
                end
                pops++;
            end
            if (bus.frame_done) begin
                done_cnt++;
                check("done_after_pops", pops, NTILES);
                check("done_queue_empty", exp_q.size(), 0);
            end
        end
    end

    initial begin
        int bound;
        reset           = 1'b1;
        bus.frame_start = 1'b0;
        bus.tile_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_addr1", bus.gpu_addr_out1, 0);
        check("rst_addr2", bus.gpu_addr_out2, 0);
        check("rst_valid", bus.tile_valid, 0);
        check("rst_busy", bus.frame_busy, 0);
        check("rst_done", bus.frame_done, 0);
        check("rst_code", bus.tile_code, 0);
        reset = 1'b0;

        // Full frame, consumer always ready.
        bus.tile_ready = 1'b1;
        start_frame();
        wait_done(3000, 1'b0);
        check("first_addr", addr_log[0], 16'h43DD);
        check("addr_c0_r2", addr_log[56], 16'h43A0);
        check("addr_c27_r33", addr_log[951], 16'h405F);
        check("addr_c0_r34", addr_log[952], 16'h401D);
        check("addr_c27_r35", addr_log[1007], 16'h4022);
        check("issue_total", issues, NTILES);
        repeat (20) @(posedge clk);
        #1;
        check("done_once", done_cnt, exp_done);
        check("idle_busy", bus.frame_busy, 0);

        // Consumer stalled: FIFO fills, issue stops, head is held.
        bus.tile_ready = 1'b0;
        start_frame();
        repeat (30) @(posedge clk);
        #1;
        check("stall_issues", issues, 8);
        check("stall_addr1", bus.gpu_addr_out1, 0);
        check("stall_valid", bus.tile_valid, 1);
        check("stall_head", {bus.tile_code, bus.tile_color, bus.tile_col, bus.tile_row},
              {8'hDD, 8'h22, 5'd0, 6'd0});
        repeat (5) @(posedge clk);
        #1;
        check("stall_hold", {bus.tile_code, bus.tile_color, bus.tile_col, bus.tile_row},
              {8'hDD, 8'h22, 5'd0, 6'd0});
        bus.tile_ready = 1'b1;
        @(posedge clk); #1;
        bus.tile_ready = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("one_pop_one_issue", issues, 9);
        check("head_after_pop", {bus.tile_code, bus.tile_col}, {8'hDC, 5'd1});
        bus.tile_ready = 1'b1;
        wait_done(3000, 1'b0);

        // Random 30% ready duty.
        start_frame();
        wait_done(20000, 1'b1);
        check("rand_pops", pops, NTILES);

        // Reset in the middle of a frame.
        bus.tile_ready = 1'b1;
        start_frame();
        bound = 0;
        while (pops < 500 && bound < 3000) begin
            @(posedge clk); #1;
            bound++;
        end
        check("reach_tile_500", (pops >= 500), 1);
        @(posedge clk); #2;
        reset = 1'b1;
        #1;
        check("arst_addr1", bus.gpu_addr_out1, 0);
        check("arst_addr2", bus.gpu_addr_out2, 0);
        check("arst_valid", bus.tile_valid, 0);
        check("arst_busy", bus.frame_busy, 0);
        check("arst_done", bus.frame_done, 0);
        exp_q.delete();
        addr_q.delete();
        pops   = 0;
        issues = 0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("no_done_after_rst", done_cnt, exp_done);
        start_frame();
        wait_done(3000, 1'b0);
        check("restart_addr", addr_log[0], 16'h43DD);

`ifdef TILE_FETCH_OVERRUN_EN
        // Extra frame_start pulses while busy are counted and ignored.
        start_frame();
        repeat (100) @(posedge clk);
        pulse_start();
        repeat (50) @(posedge clk);
        pulse_start();
        repeat (50) @(posedge clk);
        pulse_start();
        wait_done(3000, 1'b0);
        check("overrun_cnt", bus.overrun_cnt, 3);
        check("overrun_issues", issues, NTILES);
`endif

        repeat (10) @(posedge clk);
        #1;
        check("final_done_count", done_cnt, exp_done);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/pacman_tile_fetch.md
Name: pacman_tile_fetch

Overview:
- Video-side requester that feeds the memory manager's GPU port. On each frame start it scans all 28x36 Pacman tiles in row-major order and issues paired tile-code and colour addresses on the two frame-buffer read ports.
- It captures the returned bytes after the BRAM read latency and buffers them, with coordinates, in a FIFO for the downstream tile renderer.
- It drives both address ports to 0 whenever it is not issuing, so the memory manager frees the frame buffer for the CPU.

Parameters:
- FIFO_DEPTH, 8: entries in the output FIFO; power of two, minimum 4.
- RD_LAT, 1: cycles from address issue to valid fb data.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- frame_start  in  1  one-cycle pulse that begins a frame scan
- gpu_addr_out1  out  16  tile-code address (0x4000-0x43FF); 0 when not issuing
- gpu_addr_out2  out  16  colour address = gpu_addr_out1 + 0x400; 0 when not issuing
- fb_douta  in  8  frame-buffer port A data (tile code)
- fb_doutb  in  8  frame-buffer port B data (colour)
- tile_valid  out  1  FIFO head valid
- tile_ready  in  1  consumer accepts the head entry
- tile_code  out  8  head tile code
- tile_color  out  8  head colour byte
- tile_col  out  5  head column, 0..27
- tile_row  out  6  head row, 0..35
- frame_busy  out  1  high from frame_start acceptance until frame_done
- frame_done  out  1  one-cycle pulse when the last tile of the frame is popped

Behaviour:
- Reset values: all outputs 0, state IDLE, FIFO empty, pipeline cleared, counters 0.
- State IDLE:
  - On frame_start, go to FETCH with col=0, row=0, and set frame_busy.
- State FETCH:
  - Issue in a cycle iff (fifo_count + inflight) < FIFO_DEPTH.
  - Issue = drive both addresses and push {col,row} into an RD_LAT-deep tag pipeline.
  - Col increments 0..27; on wrap col->0 and row increments.
  - After issuing (col 27, row 35), go to DRAIN.
- State DRAIN:
  - When inflight==0 and the FIFO is empty, pulse frame_done, clear frame_busy, go to IDLE.
- frame_start outside IDLE: ignored.
- Address mapping, offset added to 0x4000:
  - Rows 0-1: 0x3C2 + row*32 + (27-col)
  - Rows 2-33: 0x040 + (27-col)*32 + (row-2)
  - Rows 34-35: 0x002 + (row-34)*32 + (27-col)
- Capture: RD_LAT cycles after an issue, write {fb_douta, fb_doutb, tag} into the FIFO.
  - The issue gate guarantees this never overflows.
  - Capture happens regardless of tile_ready.
- FIFO:
  - First-word-fall-through; pop when tile_valid && tile_ready.
  - Simultaneous push and pop on a full or empty FIFO is legal; the count is unchanged only when both occur.
  - Output fields hold their value while tile_valid && !tile_ready.
- Reset mid-frame: immediate return to IDLE; in-flight data discarded; no frame_done.
- The block never issues two addresses in one cycle. Throughput is 1 tile/cycle when the consumer is always ready.

Optional Feature:
- Macro: TILE_FETCH_OVERRUN_EN.
- With the macro:
  - Extra output overrun_cnt (8 bits, saturating at 255, reset 0).
  - It increments on every frame_start that arrives while frame_busy=1, including one coincident with the frame_done pulse.
- Without the macro: no port, and such pulses are silently ignored.

Decomposition:
- Package pacman_video_pkg holds:
  - TILE_COLS=28, TILE_ROWS=36, FB_BASE=16'h4000, COLOR_OFS=16'h0400.
  - typedef tile_entry_t, a packed struct {code[7:0], color[7:0], col[4:0], row[5:0]}.
  - State enum {IDLE, FETCH, DRAIN}.
- One sub-module, tile_fifo: a parameterised synchronous FWFT FIFO of tile_entry_t with count output.
- Address mapping is a package function used by the top level.

Test Plan:
- Reset, frame_start, tile_ready=1: first issue is gpu_addr_out1=0x43DD, gpu_addr_out2=0x47DD.
  - (col 0,row 2) yields 0x43A0/0x47A0; (27,33) yields 0x405F; (0,34) yields 0x401D; (27,35) yields 0x4022.
  - frame_done fires exactly once after 1008 pops.
- Frame-buffer model returns offset[7:0] as code and ~offset[7:0] as colour: every popped entry matches its col/row mapping, in row-major order.
- FIFO_DEPTH=8, tile_ready=0:
  - Exactly 8 issues occur, then the addresses read 0, tile_valid=1, and the head is held.
  - Raising tile_ready resumes issuing one tile per pop.
- Random tile_ready at 30% duty: no loss or duplication over 1008 entries; frame_busy stays high throughout.
- Reset asserted at tile 500: outputs return to 0 asynchronously and there is no frame_done.
  - A new frame_start restarts from address 0x43DD.
- With TILE_FETCH_OVERRUN_EN: three frame_start pulses during a busy frame give overrun_cnt=3, and the scan is undisturbed.
